// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Groups the write-side and status signals of the FIFO-buffered UART
//   transmitter so they travel as one port.
//   Signals:
//     tx_data      - byte to queue, sampled when tx_flag is high
//     tx_flag      - single-cycle write strobe (back-to-back allowed)
//     overflow_clr - synchronous clear of the sticky overflow flag
//     uart_txd     - registered serial line, idle high
//     tx_busy      - FSM active or bytes still queued
//     fifo_full    - FIFO holds FIFO_DEPTH bytes
//     fifo_empty   - FIFO holds no bytes
//     overflow     - sticky: a strobe was dropped because the FIFO was full
//     dbg_state    - current transmit FSM state (IDLE/START/DATA/STOP)
//   Handshake: there is no ready; a strobe while fifo_full=1 is dropped and
//   sets overflow, otherwise the byte is stored at that clock edge.
//   Modports: master drives the strobe side (system / testbench),
//             slave is the transmitter.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_flag;
  logic       overflow_clr;
  logic       uart_txd;
  logic       tx_busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic [1:0] dbg_state;

  modport master (
    output tx_data, tx_flag, overflow_clr,
    input  uart_txd, tx_busy, fifo_full, fifo_empty, overflow, dbg_state
  );

  modport slave (
    input  tx_data, tx_flag, overflow_clr,
    output uart_txd, tx_busy, fifo_full, fifo_empty, overflow, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   8N1 UART transmitter fed by a byte FIFO. Bytes strobed in are queued and
//   sent back to back with no idle gap between frames while data remains.
//   Parameters:
//     CLK_FREQ   - system clock in Hz
//     UART_BPS   - line baud rate; each line bit lasts CLK_FREQ/UART_BPS clocks
//     FIFO_DEPTH - byte FIFO depth, power of two, >= 2
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset; aborts any frame in flight and
//             discards queued bytes
//     bus   - uart_tx_fifo_if.slave (strobe input, serial line, status)
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int CW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_baud_end;
  logic [2:0]    w_next_idx;

  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = bus.tx_flag & ~w_full;
  // A strobe against a full FIFO is dropped even when a pop frees a slot in
  // the same cycle: fullness is judged on the registered count.
  assign w_drop     = bus.tx_flag & w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);
  // Pops happen only where the FSM loads a new frame: from IDLE, or at the
  // last clock of STOP so consecutive frames abut.
  assign w_pop      = ~w_empty &
                      ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_end));
  assign w_next_idx = r_bit_idx + 3'd1;

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set takes priority over clear so a drop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_overflow <= 1'b0;
    else if (w_drop)           r_overflow <= 1'b1;
    else if (bus.overflow_clr) r_overflow <= 1'b0;
  end

  // Transmit FSM. r_txd is updated on the same edge as the state change so
  // the line is fully registered and each bit lasts exactly BAUD_CNT clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_state <= S_START;
            r_txd   <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_txd     <= r_shift[0];
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= w_next_idx;
              r_txd     <= r_shift[w_next_idx];
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_state <= S_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.uart_txd   = r_txd;
  assign bus.tx_busy    = (r_state != S_IDLE) | ~w_empty;
  assign bus.fifo_full  = w_full;
  assign bus.fifo_empty = w_empty;
  assign bus.overflow   = r_overflow;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. Runs with a short bit time
//   (CLK_FREQ=1000, UART_BPS=100 -> 10 clocks per bit) so full streams fit
//   in a short run. A line monitor checks every clock of every frame against
//   the frame popped from the expected queue.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int UART_BPS = 100;
  localparam int DEPTH    = 16;
  localparam int B        = CLK_FREQ / UART_BPS;
  localparam int FRAME    = 10 * B;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  int         start_q[$];
  int         n_tests     = 0;
  int         n_fail      = 0;
  int         frames_seen = 0;
  bit         mon_active  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- line monitor ----------------
  // A falling line outside reset starts a frame; every one of its 10*B
  // clocks is compared with the expected frame (bit 0 = start bit).
  logic [9:0] mon_exp;
  logic [9:0] mon_got;
  int         mon_bad;
  bit         mon_unexp;
  bit         mon_abort;

  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && bus.uart_txd === 1'b0) begin
      mon_active = 1;
      start_q.push_back(cyc);
      mon_unexp  = (exp_q.size() == 0);
      mon_exp    = mon_unexp ? 10'h000 : exp_q.pop_front();
      mon_got    = '0;
      mon_bad    = 0;
      mon_abort  = 0;
      for (int c = 0; c < FRAME; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          mon_abort = 1;
          break;
        end
        if (c % B == B / 2) mon_got[c / B] = bus.uart_txd;
        if (bus.uart_txd !== mon_exp[c / B]) mon_bad++;
      end
      if (!mon_abort) begin
        frames_seen++;
        n_tests++;
        if (mon_unexp || mon_bad != 0) begin
          n_fail++;
          $display("FAIL frame: got %h (%0d off-time clocks, unexpected=%0d), want %h",
                   mon_got, mon_bad, mon_unexp, mon_exp);
        end
      end
      mon_active = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] d, input logic [9:0] frm, input bit accept,
                           input bit clr, output int edge_cyc);
    @(negedge clk);
    bus.tx_data      = d;
    bus.tx_flag      = 1'b1;
    bus.overflow_clr = clr;
    if (accept) exp_q.push_back(frm);
    @(posedge clk);
    #1;
    edge_cyc         = cyc;
    bus.tx_flag      = 1'b0;
    bus.overflow_clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.tx_busy !== 1'b0 || mon_active) && t < 25 * FRAME) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= 25 * FRAME) begin
      n_fail++;
      $display("FAIL %s: drain timeout, queue=%0d busy=%b, want queue=0 busy=0",
               name, exp_q.size(), bus.tx_busy);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line bits, bit 0 sent first: start, D0..D7, stop
  } vec_t;

  vec_t vecs[7];

  logic [7:0] d;
  int         k;
  int         t;
  int         errs;
  int         f0;

  initial begin
    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h3C, 10'h278};
    vecs[4] = '{8'h01, 10'h202};
    vecs[5] = '{8'h80, 10'h300};
    vecs[6] = '{8'h5A, 10'h2B4};

    bus.tx_data      = 8'h00;
    bus.tx_flag      = 1'b0;
    bus.overflow_clr = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd",   bus.uart_txd,   1);
    check("rst_busy",  bus.tx_busy,    0);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_full",  bus.fifo_full,  0);
    check("rst_ovf",   bus.overflow,   0);
    check("rst_state", bus.dbg_state,  0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single-byte frames: latency, contents and busy timing
    for (int i = 0; i < 7; i++) begin
      push_byte(vecs[i].data, vecs[i].frame, 1'b1, 1'b0, k);
      @(negedge clk);
      check("pre_start_txd", bus.uart_txd,   1);
      check("pre_start_busy", bus.tx_busy,   1);
      @(negedge clk);
      check("start_latency", bus.uart_txd,   0);
      t = 0;
      while (bus.tx_busy === 1'b1 && t < 2 * FRAME) begin
        @(negedge clk);
        t++;
      end
      check("busy_fall_cycle", cyc, k + 1 + FRAME);
      wait_drain("single_drain");
    end

    // Paced stream: one strobe per frame time, frames must abut
    start_q.delete();
    errs = 0;
    for (int i = 0; i < 18; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i > 0) begin
        repeat (FRAME - 1) @(posedge clk);
        #1;
        if (bus.fifo_empty !== 1'b1) errs++;
      end
      push_byte(d, {1'b1, d, 1'b0}, 1'b1, 1'b0, k);
    end
    wait_drain("paced_drain");
    check("paced_count_le1", errs, 0);
    check("paced_frames", start_q.size(), 18);
    errs = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != FRAME) errs++;
    check("paced_no_gap", errs, 0);
    check("paced_ovf", bus.overflow, 0);

    // Burst of 20 back-to-back strobes; last one races overflow_clr
    f0 = frames_seen;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      push_byte(d, {1'b1, d, 1'b0}, (i < 17), (i == 19), k);
      if (i == 15) check("burst_not_full_k15", bus.fifo_full, 0);
      if (i == 16) check("burst_full_k16",     bus.fifo_full, 1);
      if (i == 16) check("burst_ovf_before",   bus.overflow,  0);
      if (i == 17) check("burst_ovf_set",      bus.overflow,  1);
    end
    check("clr_race_set_wins", bus.overflow, 1);
    @(negedge clk);
    bus.overflow_clr = 1'b1;
    @(posedge clk);
    #1 bus.overflow_clr = 1'b0;
    check("clr_alone", bus.overflow, 0);
    wait_drain("burst_drain");
    check("burst_frames", frames_seen - f0, 17);

    // Reset in DATA bit 3 with bytes queued
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      push_byte(d, {1'b1, d, 1'b0}, 1'b1, 1'b0, t);
      if (i == 0) k = t;
    end
    while (cyc < k + 1 + 4 * B + B / 2) @(posedge clk);
    #1;
    check("pre_rst_state_data", bus.dbg_state, 2);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_txd",   bus.uart_txd,   1);
    check("midrst_empty", bus.fifo_empty, 1);
    check("midrst_busy",  bus.tx_busy,    0);
    check("midrst_state", bus.dbg_state,  0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    f0 = frames_seen;
    push_byte(8'h3C, 10'h278, 1'b1, 1'b0, k);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_latency", bus.uart_txd, 0);
    wait_drain("post_rst_drain");
    check("post_rst_frames", frames_seen - f0, 1);
    check("post_rst_ovf", bus.overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
